// File: rtl/seg_addsub_unit.sv
// Multi-cycle adder/subtractor: one SEG_W-bit segment per clock, carry held in a register.
// Optional: define ADDER_SAT_EN to saturate Sum on signed overflow.
module seg_addsub_unit #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] Num_1,
    input  logic [WIDTH-1:0] Num_2,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             OV,
    output logic             ZF,
    output logic             NF,
    output logic             CF,
    output logic             Busy
);

    localparam int NSEG  = WIDTH / SEG_W;
    localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;   // already inverted for subtract
        logic             sub;
    } op_t;

    state_t           state;
    op_t              op;
    logic             carry;
    logic [IDX_W-1:0] seg_idx;
    logic [WIDTH-1:0] work_sum;

    int               seg_base;
    logic [SEG_W-1:0] seg_a, seg_b;
    logic [SEG_W:0]   seg_res;
    logic             last_seg, c_out, c_msb, ov;
    logic [WIDTH-1:0] full_sum, res_sum;

    always_comb begin
        seg_base = int'(seg_idx) * SEG_W;
        seg_a    = op.a[seg_base +: SEG_W];
        seg_b    = op.b[seg_base +: SEG_W];
        seg_res  = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, carry};
        last_seg = (seg_idx == IDX_W'(NSEG - 1));
        c_out    = seg_res[SEG_W];
        // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
        c_msb    = seg_res[SEG_W-1] ^ seg_a[SEG_W-1] ^ seg_b[SEG_W-1];
        ov       = c_msb ^ c_out;
        full_sum = work_sum;
        full_sum[seg_base +: SEG_W] = seg_res[SEG_W-1:0];
        res_sum  = full_sum;
`ifdef ADDER_SAT_EN
        if (ov)
            res_sum = op.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    assign In_ready = (state == IDLE);
    assign Busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= '0;
            carry     <= 1'b0;
            seg_idx   <= '0;
            work_sum  <= '0;
            Sum       <= '0;
            Cout      <= 1'b0;
            OV        <= 1'b0;
            ZF        <= 1'b0;
            NF        <= 1'b0;
            CF        <= 1'b0;
            Out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_valid) begin
                        op.a     <= Num_1;
                        op.b     <= Sub ? ~Num_2 : Num_2;
                        op.sub   <= Sub;
                        carry    <= Sub ? ~Cin : Cin;
                        seg_idx  <= '0;
                        work_sum <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    carry    <= c_out;
                    work_sum <= full_sum;
                    if (last_seg) begin
                        Sum       <= res_sum;
                        Cout      <= c_out;
                        OV        <= ov;
                        ZF        <= (res_sum == '0);
                        NF        <= res_sum[WIDTH-1];
                        CF        <= op.sub ? ~c_out : c_out;
                        Out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        seg_idx <= seg_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (Out_ready) begin
                        Out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_addsub_unit.sv
// Randomized bench for seg_addsub_unit: 32/8 instance and a 16/16 (single segment) instance,
// both checked against an arithmetic reference model.
module tb_seg_addsub_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit, 4-segment instance
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ov, zf, nf, cf, busy;
    logic [31:0] num_1, num_2, sum;
    // 16-bit, single-segment instance
    logic        in_valid_h, in_ready_h, cin_h, sub_h, out_valid_h, out_ready_h;
    logic        cout_h, ov_h, zf_h, nf_h, cf_h, busy_h;
    logic [15:0] num_1_h, num_2_h, sum_h;

    seg_addsub_unit #(.WIDTH(32), .SEG_W(8)) u_dut (
        .clk(clk), .rst(rst), .In_valid(in_valid), .In_ready(in_ready),
        .Num_1(num_1), .Num_2(num_2), .Cin(cin), .Sub(sub),
        .Out_valid(out_valid), .Out_ready(out_ready), .Sum(sum),
        .Cout(cout), .OV(ov), .ZF(zf), .NF(nf), .CF(cf), .Busy(busy));

    seg_addsub_unit #(.WIDTH(16), .SEG_W(16)) u_dut_h (
        .clk(clk), .rst(rst), .In_valid(in_valid_h), .In_ready(in_ready_h),
        .Num_1(num_1_h), .Num_2(num_2_h), .Cin(cin_h), .Sub(sub_h),
        .Out_valid(out_valid_h), .Out_ready(out_ready_h), .Sum(sum_h),
        .Cout(cout_h), .OV(ov_h), .ZF(zf_h), .NF(nf_h), .CF(cf_h), .Busy(busy_h));

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] e_sum;
    logic        e_cout, e_ov, e_zf, e_nf, e_cf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic over w-bit operands
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic sb_op);
        longint m, half, ua, ub, c, sa, sb, t, st;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        c    = ci ? 1 : 0;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        if (!sb_op) begin
            t      = ua + ub + c;
            e_cout = (t > m);
            st     = sa + sb + c;
        end else begin
            t      = ua - ub - c;
            e_cout = !(ua < ub + c);
            st     = sa - sb - c;
        end
        e_sum = 32'(t & m);
        e_ov  = (st > half - 1) || (st < -half);
`ifdef ADDER_SAT_EN
        if (e_ov) e_sum = 32'((st > 0) ? half - 1 : half);
`endif
        e_zf = (e_sum == 0);
        e_nf = e_sum[w-1];
        e_cf = sb_op ? !e_cout : e_cout;
    endfunction

    task automatic chk_res(input string tag);
        chk({tag, ".sum"},  64'(sum),  64'(e_sum));
        chk({tag, ".cout"}, 64'(cout), 64'(e_cout));
        chk({tag, ".ov"},   64'(ov),   64'(e_ov));
        chk({tag, ".zf"},   64'(zf),   64'(e_zf));
        chk({tag, ".nf"},   64'(nf),   64'(e_nf));
        chk({tag, ".cf"},   64'(cf),   64'(e_cf));
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic sb_op, input int stall);
        int g, lat;
        model(32, a, b, ci, sb_op);
        g = 0;
        while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        num_1 = a; num_2 = b; cin = ci; sub = sb_op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        num_1 = $urandom; num_2 = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("latency", 64'(lat), 64'd4);
        for (int i = 0; i < stall; i++) begin
            chk_res("stall");
            chk("stall.in_ready", 64'(in_ready), 64'd0);
            chk("stall.out_valid", 64'(out_valid), 64'd1);
            in_valid = 1'b1;   // must be ignored while busy
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk_res("done");
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post.out_valid", 64'(out_valid), 64'd0);
        chk("post.in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb_op);
        int lat;
        model(16, 32'(a), 32'(b), ci, sb_op);
        num_1_h = a; num_2_h = b; cin_h = ci; sub_h = sb_op; in_valid_h = 1'b1;
        @(posedge clk); #1;
        in_valid_h = 1'b0; num_1_h = 16'($urandom); num_2_h = 16'($urandom);
        lat = 0;
        while (!out_valid_h && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("h.latency", 64'(lat), 64'd1);
        chk("h.sum",  64'(sum_h),  64'(e_sum[15:0]));
        chk("h.cout", 64'(cout_h), 64'(e_cout));
        chk("h.ov",   64'(ov_h),   64'(e_ov));
        chk("h.zf",   64'(zf_h),   64'(e_zf));
        chk("h.nf",   64'(nf_h),   64'(e_nf));
        chk("h.cf",   64'(cf_h),   64'(e_cf));
        out_ready_h = 1'b1;
        @(posedge clk); #1;
        out_ready_h = 1'b0;
        chk("h.in_ready", 64'(in_ready_h), 64'd1);
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: pick32 = 32'h0000_0000;
            1: pick32 = 32'hFFFF_FFFF;
            2: pick32 = 32'h7FFF_FFFF;
            3: pick32 = 32'h8000_0000;
            default: pick32 = $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; num_1 = '0; num_2 = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        in_valid_h = 1'b0; num_1_h = '0; num_2_h = '0; cin_h = 1'b0; sub_h = 1'b0; out_ready_h = 1'b0;
        #1;
        in_valid = 1'b1;   // ignored while in reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.flags", 64'({sum, cout, ov, zf, nf, cf}), 64'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // directed cases
        op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);
        op32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
        op32(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0);
        op32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
        op32(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 5);   // backpressure
        op32(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0, 0);   // op following stalled one

        // reset aborts an operation mid-RUN
        num_1 = 32'hAAAA_AAAA; num_2 = 32'h5555_5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.flags", 64'({sum, cout, ov, zf, nf, cf}), 64'd0);
        chk("abort.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        op32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++)
            op32(pick32(), pick32(), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        // single-segment configuration
        op16(16'h8000, 16'h8000, 1'b0, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h0005, 16'h0007, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
